ehl_buffer_unpacker: RTL and testbench

//   Downstream drain stage for the shift/pointer data buffer: pops DATA words via rd/empty and

---
 rtl/ehl_buffer_unpacker.sv | 92 +++++++++
 tb/tb_ehl_buffer_unpacker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ehl_buffer_unpacker.sv
// Drains a first-word-fall-through buffer and serialises each IN_WIDTH word into
// IN_WIDTH/OUT_WIDTH beats on a valid/ready stream, prefetching on the last beat.
module ehl_buffer_unpacker #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 buf_empty,
  input  logic [IN_WIDTH-1:0]  buf_data,
  output logic                 buf_rd,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_width
    $error("ehl_buffer_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH");
  end

  logic [IN_WIDTH-1:0] w_q, w_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                v_q, v_d;
  logic                accept;
  logic                fin;
  logic [CW-1:0]       slice_idx;

  // Pop strobe: only when not flushing, data present, and register free or freeing this cycle
  always_comb begin
    accept = v_q & out_ready;
    fin    = accept & (cnt_q == LAST_CNT);
    buf_rd = reset_n & ~flush & ~buf_empty & (~v_q | fin);
  end

  // Next state in priority order: flush, load, finish, advance, hold
  always_comb begin
    w_d   = w_q;
    cnt_d = cnt_q;
    v_d   = v_q;
    if (flush) begin
      v_d   = 1'b0;
      cnt_d = '0;
    end else if (buf_rd) begin
      w_d   = buf_data;
      cnt_d = '0;
      v_d   = 1'b1;
    end else if (fin) begin
      v_d   = 1'b0;
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q   <= '0;
      cnt_q <= '0;
      v_q   <= 1'b0;
    end else begin
      w_q   <= w_d;
      cnt_q <= cnt_d;
      v_q   <= v_d;
    end
  end

  // Beat slice selection; reversed count walks slices from the top for MSB_FIRST
  always_comb begin
    slice_idx = MSB_FIRST ? (LAST_CNT - cnt_q) : cnt_q;
    out_data  = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (slice_idx == CW'(i)) begin
        out_data = w_q[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  always_comb begin
    out_valid = v_q;
    busy      = v_q;
    out_last  = v_q & (cnt_q == LAST_CNT);
  end

endmodule

// File: tb/tb_ehl_buffer_unpacker.sv
// Scoreboard bench: two unpackers (LSB-first and MSB-first) share one buffer model and sink.
module tb_ehl_buffer_unpacker;

  logic        clk;
  logic        reset_n;
  logic        buf_empty;
  logic [15:0] buf_data;
  logic        flush;
  logic        out_ready;
  logic        buf_rd0, buf_rd1;
  logic        out_valid0, out_valid1;
  logic [3:0]  out_data0, out_data1;
  logic        out_last0, out_last1;
  logic        busy0, busy1;

  ehl_buffer_unpacker #(.IN_WIDTH(16), .OUT_WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .buf_empty(buf_empty), .buf_data(buf_data),
    .buf_rd(buf_rd0), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_last(out_last0), .busy(busy0)
  );

  ehl_buffer_unpacker #(.IN_WIDTH(16), .OUT_WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .buf_empty(buf_empty), .buf_data(buf_data),
    .buf_rd(buf_rd1), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_last(out_last1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] bufq[$];
  logic [4:0]  exp0[$];
  logic [4:0]  exp1[$];
  logic        rd_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic update_buf();
    buf_empty = (bufq.size() == 0);
    buf_data  = buf_empty ? 16'h0 : bufq[0];
  endtask

  // Queue a word in the buffer and the first nb beats it is expected to produce
  task automatic push_word(input logic [15:0] w, input int nb);
    logic [15:0] wv;
    wv = w;
    bufq.push_back(wv);
    for (int k = 0; k < nb; k++) begin
      exp0.push_back({(k == 3), wv[k*4 +: 4]});
      exp1.push_back({(k == 3), wv[(3-k)*4 +: 4]});
    end
    update_buf();
  endtask

  task automatic next_cycle(input logic rdy, input logic fl);
    logic [15:0] dropped;
    @(negedge clk);
    if (rd_seen && bufq.size() != 0) dropped = bufq.pop_front();
    out_ready = rdy;
    flush     = fl;
    update_buf();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      next_cycle(1'b1, 1'b0);
      if (exp0.size() == 0 && exp1.size() == 0) break;
    end
    chk("drain_lsb_empty", 32'(exp0.size()), 32'd0);
    chk("drain_msb_empty", 32'(exp1.size()), 32'd0);
    chk("drain_idle", 32'({out_valid0, out_valid1}), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'({out_valid0, out_valid1}), 32'd0);
    chk({tag, "_last"},  32'({out_last0, out_last1}), 32'd0);
    chk({tag, "_data"},  32'({out_data0, out_data1}), 32'd0);
    chk({tag, "_busy"},  32'({busy0, busy1}), 32'd0);
    chk({tag, "_rd"},    32'({buf_rd0, buf_rd1}), 32'd0);
  endtask

  // Monitor: samples 3ns after the falling edge, well clear of the rising edge
  initial begin : monitor
    logic       prev_valid, prev_ready, prev_flush;
    logic [3:0] prev_data;
    logic [4:0] e;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_flush = 1'b0; prev_data = 4'h0;
    forever begin
      @(negedge clk);
      #3;
      if (!reset_n) begin
        rd_seen    = 1'b0;
        prev_valid = 1'b0;
      end else begin
        rd_seen = buf_rd0;
        chk("rd_match", 32'(buf_rd1), 32'(buf_rd0));
        if (buf_empty) chk("rd_when_empty", 32'(buf_rd0), 32'd0);
        if (flush) chk("rd_during_flush", 32'(buf_rd0), 32'd0);
        if (buf_rd0 && out_valid0) chk("rd_mid_word", 32'({out_last0, out_ready}), 32'h3);
        if (prev_valid && !prev_ready && !prev_flush) begin
          chk("stall_valid", 32'(out_valid0), 32'd1);
          chk("stall_data", 32'(out_data0), 32'(prev_data));
        end
        chk("busy_lsb", 32'(busy0), 32'(out_valid0));
        chk("busy_msb", 32'(busy1), 32'(out_valid1));
        if (out_valid0 && out_ready && !flush) begin
          if (exp0.size() == 0) chk("beat_lsb_unexpected", 32'({out_last0, out_data0}), 32'hFFFF);
          else begin
            e = exp0.pop_front();
            chk("beat_lsb", 32'({out_last0, out_data0}), 32'(e));
          end
        end
        if (out_valid1 && out_ready && !flush) begin
          if (exp1.size() == 0) chk("beat_msb_unexpected", 32'({out_last1, out_data1}), 32'hFFFF);
          else begin
            e = exp1.pop_front();
            chk("beat_msb", 32'({out_last1, out_data1}), 32'(e));
          end
        end
        prev_valid = out_valid0;
        prev_ready = out_ready;
        prev_flush = flush;
        prev_data  = out_data0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    reset_n   = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    update_buf();

    // Reset with A5C3 already at the buffer head: nothing popped, outputs quiet
    push_word(16'hA5C3, 4);
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");

    // Single word, LSB-first 3,C,5,A and MSB-first A,5,C,3
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("first_rd", 32'(buf_rd0), 32'd1);
    repeat (5) next_cycle(1'b1, 1'b0);
    chk("t1_consumed", 32'(exp0.size()), 32'd0);
    chk("t1_idle", 32'(out_valid0), 32'd0);

    // Two queued words stream back to back: 8 beats in 8 clocks
    push_word(16'h1234, 4);
    push_word(16'h5678, 4);
    repeat (9) next_cycle(1'b1, 1'b0);
    chk("t2_no_gap", 32'(exp0.size()), 32'd0);
    chk("t2_idle", 32'(out_valid0), 32'd0);

    // Backpressure pattern 1,0,0 repeating
    push_word(16'h9ABC, 4);
    push_word(16'hDEF0, 4);
    for (int i = 0; i < 30; i++) next_cycle((i % 3) == 0, 1'b0);
    drain(20);

    // Empty buffer: nothing popped, nothing presented
    repeat (8) next_cycle(1'b1, 1'b0);
    chk("t4_idle", 32'(out_valid0), 32'd0);
    chk("t4_no_rd", 32'(buf_rd0), 32'd0);

    // Flush after two beats of BEEF; 0F0F follows, BEEF's E,B never appear
    next_cycle(1'b1, 1'b0);
    push_word(16'hBEEF, 2);
    next_cycle(1'b1, 1'b0);
    next_cycle(1'b1, 1'b0);
    next_cycle(1'b1, 1'b1);
    push_word(16'h0F0F, 4);
    #1;
    chk("flush_no_rd", 32'(buf_rd0), 32'd0);
    next_cycle(1'b1, 1'b0);
    #1;
    chk("post_flush_rd", 32'(buf_rd0), 32'd1);
    drain(20);

    // Async reset one beat into 1234: word dropped, 5678 starts at its first slice
    next_cycle(1'b1, 1'b0);
    push_word(16'h1234, 1);
    push_word(16'h5678, 4);
    next_cycle(1'b1, 1'b0);
    next_cycle(1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    next_cycle(1'b1, 1'b0);
    reset_n = 1'b1;
    drain(20);

    chk("final_lsb_empty", 32'(exp0.size()), 32'd0);
    chk("final_msb_empty", 32'(exp1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
